// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: free-running h/v counters advanced on ce,
// with every output registered from the same pre-increment position.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 128,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 9,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 28,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CNT_W     = 11,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int FCW       = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    output logic           hsync,
    output logic           vsync,
    output logic           activevideo,
    output logic [XW-1:0]  x_px,
    output logic [YW-1:0]  y_px,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_BLANK_C = CNT_W'(H_BLANK);
    localparam logic [CNT_W-1:0] V_BLANK_C = CNT_W'(V_BLANK);
    localparam logic             HS_ON     = (HSYNC_POL != 0);
    localparam logic             VS_ON     = (VSYNC_POL != 0);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;

    always_comb begin
        hc_d = hc_q + CNT_W'(1);
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
        end
    end

    // Decode of the position the counters are about to leave.
    always_comb begin
        hsync_d  = (hc_q >= H_SYNC_LO && hc_q < H_SYNC_HI) ? HS_ON : ~HS_ON;
        vsync_d  = (vc_q >= V_SYNC_LO && vc_q < V_SYNC_HI) ? VS_ON : ~VS_ON;
        active_d = (hc_q >= H_BLANK_C) && (vc_q >= V_BLANK_C);
        x_d      = '0;
        y_d      = '0;
        if (active_d) begin
            x_d = XW'(hc_q - H_BLANK_C);
            y_d = YW'(vc_q - V_BLANK_C);
        end
        line_d  = (hc_q == '0);
        frame_d = (hc_q == '0) && (vc_q == '0);
        fcnt_d  = frame_d ? fcnt_q + FCW'(1) : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q     <= '0;
            vc_q     <= '0;
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            fcnt_q   <= '0;
        end else if (ce) begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            fcnt_q   <= fcnt_d;
        end else begin
            // Strobes last one clk even when ce is sparse.
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign activevideo = active_q;
    assign x_px        = x_q;
    assign y_px        = y_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: fixed vector table, randomised ce/reset against a
// position-index model, and hand sequences for periods, wrap and mid-frame reset.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HBL = HF + HS + HB, HT = HBL + HA;
    localparam int VBL = VF + VS + VB, VT = VBL + VA;
    localparam int XW = 10, YW = 10, FCW = 2;

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           av;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic           ls;
        logic           fs;
        logic [FCW-1:0] fc;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  ce;
        outs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;

    logic           hs_a, vs_a, av_a, ls_a, fs_a;
    logic [XW-1:0]  x_a;
    logic [YW-1:0]  y_a;
    logic [FCW-1:0] fc_a;
    logic           hs_b, vs_b, av_b, ls_b, fs_b;
    logic [XW-1:0]  x_b;
    logic [YW-1:0]  y_b;
    logic [FCW-1:0] fc_b;
    outs_t got_a, got_b;

    assign got_a = {hs_a, vs_a, av_a, x_a, y_a, ls_a, fs_a, fc_a};
    assign got_b = {hs_b, vs_b, av_b, x_b, y_b, ls_b, fs_b, fc_b};

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .CNT_W(11), .XW(XW), .YW(YW), .FCW(FCW)
    ) dut_a (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(hs_a), .vsync(vs_a), .activevideo(av_a), .x_px(x_a), .y_px(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(11), .XW(XW), .YW(YW), .FCW(FCW)
    ) dut_b (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(hs_b), .vsync(vs_b), .activevideo(av_b), .x_px(x_b), .y_px(y_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n = 0;
    bit strobe = 0;
    vec_t tbl[21];
    int lsq[$];
    int fsq[$];
    int fcq[$];

    // n = ce edges since reset; the outputs describe pixel index n-1.
    function automatic outs_t model(input int cnt, input bit stb, input bit pol);
        outs_t o;
        int p, h, v;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        if (cnt > 0) begin
            p = cnt - 1;
            h = p % HT;
            v = (p / HT) % VT;
            o.hs = (h >= HF && h < HF + HS) ? pol : ~pol;
            o.vs = (v >= VF && v < VF + VS) ? pol : ~pol;
            o.av = (h >= HBL) && (v >= VBL);
            if (o.av) begin
                o.x = XW'(h - HBL);
                o.y = YW'(v - VBL);
            end
            o.ls = stb && (h == 0);
            o.fs = stb && (h == 0) && (v == 0);
            o.fc = FCW'(p / (HT * VT) + 1);
        end
        return o;
    endfunction

    function automatic outs_t mk(input logic hs, input logic vs, input logic av,
                                 input int x, input int y, input logic ls,
                                 input logic fs, input int fc);
        outs_t o;
        o.hs = hs; o.vs = vs; o.av = av;
        o.x = XW'(x); o.y = YW'(y);
        o.ls = ls; o.fs = fs; o.fc = FCW'(fc);
        return o;
    endfunction

    task automatic check_o(input string name, input outs_t got, input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got hs=%b vs=%b av=%b x=%0d y=%0d ls=%b fs=%b fc=%0d, want hs=%b vs=%b av=%b x=%0d y=%0d ls=%b fs=%b fc=%0d (n=%0d)",
                     name, got.hs, got.vs, got.av, got.x, got.y, got.ls, got.fs, got.fc,
                     exp.hs, exp.vs, exp.av, exp.x, exp.y, exp.ls, exp.fs, exp.fc, n);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic c);
        reset = r;
        ce = c;
        @(posedge clk);
        #1;
        if (r) begin
            n = 0;
            strobe = 0;
        end else if (c) begin
            n++;
            strobe = 1;
        end else begin
            strobe = 0;
        end
        check_o("model_pol0", got_a, model(n, strobe, 1'b0));
        check_o("model_pol1", got_b, model(n, strobe, 1'b1));
    endtask

    initial begin
        outs_t rv;
        rv = mk(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b1, rv};
        tbl[3] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 1, 1, 1)};
        tbl[4] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 1)};
        tbl[5] = '{1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 1)};
        for (int i = 6; i < 9; i++) tbl[i] = '{1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 1)};
        for (int i = 9; i < 18; i++) tbl[i] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 1)};
        tbl[18] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 1, 0, 1)};
        tbl[19] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 1)};
        tbl[20] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 1)};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].ce);
            check_o($sformatf("tbl[%0d]", i), got_a, tbl[i].e);
        end

        // Random ce duty and occasional reset.
        step(1'b1, 1'b1);
        for (int k = 0; k < 3000; k++)
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));

        // Reset while counters sit at (hc=10, vc=5).
        step(1'b1, 1'b1);
        for (int k = 0; k < 5 * HT + 10; k++) step(1'b0, 1'b1);
        check_o("mid_before", got_a, mk(1, 1, 1, 3, 1, 0, 0, 1));
        step(1'b1, 1'b1);
        check_o("mid_reset", got_a, rv);
        step(1'b0, 1'b1);
        check_o("mid_restart", got_a, mk(1, 1, 0, 0, 0, 1, 1, 1));

        // Four frames at full rate: frame_count wrap and frame period.
        step(1'b1, 1'b1);
        for (int k = 0; k < 4 * HT * VT; k++) begin
            step(1'b0, 1'b1);
            if (fs_a) begin
                fsq.push_back(k);
                fcq.push_back(int'(fc_a));
            end
        end
        check_i("wrap_count", fcq.size(), 4);
        for (int i = 0; i < fcq.size() && i < 4; i++)
            check_i($sformatf("wrap_fc[%0d]", i), fcq[i], (i + 1) % 4);
        for (int i = 1; i < fsq.size(); i++)
            check_i("frame_period", fsq[i] - fsq[i-1], HT * VT);

        // ce every other clk: periods double, strobes stay one clk wide.
        fsq.delete();
        step(1'b1, 1'b1);
        for (int k = 0; k < 500; k++) begin
            step(1'b0, (k % 2) == 0);
            if (ls_a) lsq.push_back(k);
            if (fs_a) fsq.push_back(k);
        end
        check_i("half_fs_count", fsq.size(), 3);
        for (int i = 1; i < lsq.size(); i++)
            check_i("half_line_period", lsq[i] - lsq[i-1], 2 * HT);
        for (int i = 1; i < fsq.size(); i++)
            check_i("half_frame_period", fsq[i] - fsq[i-1], 2 * HT * VT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator and successor to the fixed 640x480@72Hz sync generator.
- All porch, sync and active lengths and both sync polarities are parameters.
- A clock enable lets it run from a system clock rather than a dedicated pixel clock.
- Provides synchronous reset, fully registered and mutually aligned outputs, line/frame strobes and a frame counter.
- Sits between the clock/PLL block and the pixel renderers; the PLL stays outside this block.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 40, hsync pulse (pixels)
H_BP, 128, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 9, vertical front porch (lines)
V_SYNC, 3, vsync pulse (lines)
V_BP, 28, vertical back porch (lines)
HSYNC_POL, 0, asserted hsync level (0 = active-low)
VSYNC_POL, 0, asserted vsync level (0 = active-low)
CNT_W, 11, internal counter width; H_TOTAL and V_TOTAL must each be <= 2^CNT_W
XW, 10, width of x_px
YW, 10, width of y_px
FCW, 8, width of frame_count

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
ce  in  1  pixel enable; timing advances only on clk edges with ce=1 (tie high for one pixel per clk)
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
activevideo  out  1  high while the current pixel is visible
x_px  out  XW  visible column 0..H_ACTIVE-1; 0 when not active
y_px  out  YW  visible row 0..V_ACTIVE-1; 0 when not active
line_start  out  1  one-clk strobe at horizontal position 0 of every line
frame_start  out  1  one-clk strobe at position (0,0) of every frame
frame_count  out  FCW  frames started since reset, wrapping

Behaviour:
- Definitions: H_BLANK = H_FP+H_SYNC+H_BP; H_TOTAL = H_BLANK+H_ACTIVE; V_BLANK and V_TOTAL are defined the same way.
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1), each CNT_W bits.
- Line order: front porch [0,H_FP), sync [H_FP,H_FP+H_SYNC), back porch, then active [H_BLANK,H_TOTAL). Vertical order is the same.
- On each clk edge with reset=0 and ce=1:
  - hc increments; at H_TOTAL-1, hc wraps to 0 and vc increments.
  - vc wraps to 0 when vc=V_TOTAL-1 and hc=H_TOTAL-1.
- On the same ce edge, all outputs register a decode of the pre-increment (hc,vc). Every output therefore describes the same position, one clk after the counters leave it; no output lags another.
- Decode rules:
  - hsync = HSYNC_POL when hc is in the sync interval, otherwise ~HSYNC_POL. vsync is analogous on vc.
  - activevideo = (hc >= H_BLANK) && (vc >= V_BLANK).
  - x_px = hc-H_BLANK and y_px = vc-V_BLANK when active, else both 0. Truncate to XW/YW.
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
- When ce=0, counters and level outputs hold.
- line_start and frame_start clear on every clk edge where ce=0, so each is high for exactly one clk regardless of the ce duty cycle.
- frame_count increments (mod 2^FCW) on the same edge that raises frame_start.
- The first frame_start after reset is counted, so frame_count reads 1 alongside it.
- Reset (any cycle, with or without ce, including mid-line or mid-frame): hc=vc=0, frame_count=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, activevideo=0, x_px=y_px=0, line_start=frame_start=0.
- Reset takes priority over ce.
- The first ce edge after reset decodes position (0,0), which raises line_start and frame_start.
- Latency: 1 clk from the counter position to the outputs.
- Frame period: H_TOTAL*V_TOTAL ce-enabled edges.
- Legal parameter sets require every length >= 1.

Test Plan:
Parameters used unless a scenario says otherwise: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); FCW=2; ce=1.
- Reset held for 3 clks with ce=1 -> all outputs at reset values. First clk after release: line_start=frame_start=1, frame_count=1, hsync=vsync=1.
- Horizontal timing -> hsync low for exactly 3 clks, beginning 2 clks after line_start. activevideo high for 8 clks on active lines with x_px=0..7. line_start period is 14 clks.
- Vertical timing -> vsync low for lines 1-2 (28 clks). activevideo first rises at line 4 with y_px=0, and y_px=3 on the last line. frame_start period is 112 clks.
- ce asserted every other clk -> all periods double (line 28 clks, frame 224 clks). line_start and frame_start each stay high for only 1 clk.
- Wrap: run 4 frames -> frame_count reads 1,2,3,0 at successive frame_start pulses.
- Reset asserted mid-active (hc=10, vc=5) for 1 clk -> outputs return to reset values. Next edge restarts at (0,0) with frame_start=1 and frame_count=1.
- Polarity: HSYNC_POL=1, VSYNC_POL=1 -> hsync/vsync idle low and pulse high with identical timing.
